// File: rtl/pipe_perf_counters.sv
// pipe_perf_counters: per-cycle event counter bank with cycle limit, sticky overflow and coherent snapshot read
module pipe_perf_counters #(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 32,
  parameter int SAT_MODE = 0,
  parameter int SEL_W    = $clog2(NUM_CH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              clr_i,
  input  logic [NUM_CH-1:0] event_i,
  input  logic [CNT_W-1:0]  limit_i,
  input  logic              snap_i,
  input  logic [SEL_W-1:0]  rd_sel_i,
  output logic [CNT_W-1:0]  rd_data_o,
  output logic [NUM_CH-1:0] ovf_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  cycle_o
);
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [CNT_W-1:0]  sh_q [NUM_CH+1];
  logic [CNT_W-1:0]  cyc_q, cyc_d, rd_q, rd_d;
  logic [NUM_CH-1:0] ovf_q, ovf_d;
  logic              done_q, done_d, active;

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
    return (&v && SAT_MODE != 0) ? v : v + CNT_W'(1);
  endfunction

  // next-state for live counters, overflow flags, limit stop and the shadow read mux
  always_comb begin
    active = en_i && !done_q && !clr_i;
    cyc_d  = clr_i ? '0 : active ? bump(cyc_q) : cyc_q;
    done_d = !clr_i && (done_q || (active && limit_i != '0 && cyc_q == limit_i - CNT_W'(1)));
    ovf_d  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cnt_d[k] = clr_i ? '0 : (active && event_i[k]) ? bump(cnt_q[k]) : cnt_q[k];
      ovf_d[k] = !clr_i && (ovf_q[k] || (active && event_i[k] && &cnt_q[k]));
    end
    rd_d = '0;
    for (int i = 0; i <= NUM_CH; i++)
      if (rd_sel_i == SEL_W'(i)) rd_d = sh_q[i];
  end

  // state update; snapshot captures pre-edge live values independent of clear/count
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= '0;
      for (int i = 0; i <= NUM_CH; i++) sh_q[i] <= '0;
      cyc_q  <= '0;
      rd_q   <= '0;
      ovf_q  <= '0;
      done_q <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= cnt_d[k];
      if (snap_i) begin
        for (int k = 0; k < NUM_CH; k++) sh_q[k] <= cnt_q[k];
        sh_q[NUM_CH] <= cyc_q;
      end
      cyc_q  <= cyc_d;
      rd_q   <= rd_d;
      ovf_q  <= ovf_d;
      done_q <= done_d;
    end
  end

  assign rd_data_o = rd_q;
  assign ovf_o     = ovf_q;
  assign done_o    = done_q;
  assign cycle_o   = cyc_q;
endmodule

// File: doc/pipe_perf_counters.md
# pipe_perf_counters

Synthesizable event-counter bank for the pipelined CPU. It gives hardware counts of per-cycle events, such as load-use stalls, branch flushes and retired instructions, with a run-cycle counter and an optional cycle limit. A snapshot-and-read port lets software or a bench sample all counters coherently. It sits beside the CPU core and is fed single-bit event strobes from the hazard unit, the control unit and the writeback stage.

## Interface
- NUM_CH, 4: number of event channels (1..16).
- CNT_W, 32: width of every counter, including the cycle counter (8..64).
- SAT_MODE, 0: 0 = counters wrap modulo 2^CNT_W; 1 = counters saturate at 2^CNT_W-1.
- SEL_W, $clog2(NUM_CH+1): width of the read select.

- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous reset, active-high.
- en_i  in  1  counting enable.
- clr_i  in  1  synchronous clear of live counters, cycle counter, overflow flags and done.
- event_i  in  NUM_CH  per-channel event strobe; counts +1 per cycle while high.
- limit_i  in  CNT_W  cycle limit; 0 = unlimited.
- snap_i  in  1  copy all live counters into shadow registers.
- rd_sel_i  in  SEL_W  shadow select: 0..NUM_CH-1 = channel, NUM_CH = cycle counter.
- rd_data_o  out  CNT_W  registered shadow read data.
- ovf_o  out  NUM_CH  sticky per-channel overflow flags.
- done_o  out  1  cycle limit reached; counting frozen.
- cycle_o  out  CNT_W  live cycle counter.

## Operation
- Reset (rst_i=1) zeroes all of the following:
  - live counters, shadow registers and cycle_o;
  - rd_data_o, ovf_o and done_o.
- Update priority on each edge: rst_i > clr_i > counting. snap_i is evaluated independently of that chain.
- Active cycle: en_i=1 && done_o=0 && clr_i=0.
- In an active cycle:
  - the cycle counter increments by 1;
  - each channel with event_i[k]=1 increments by 1;
  - channels with event_i[k]=0 hold.
- When en_i=0 or done_o=1, all live counters hold.
- Cycle limit: if limit_i!=0 and an active edge moves cycle_o from limit_i-1 to limit_i, done_o goes to 1 on that same edge.
  - Events in that final cycle are counted.
  - done_o stays 1 until clr_i or rst_i.
  - If limit_i is changed while done_o=1, done_o stays 1.
  - If limit_i is set to a value ≤ the current cycle_o while counting, done_o does not assert until wrap/saturation logic reaches equality; no retroactive stop.
- Overflow, SAT_MODE=0: an increment from all-ones wraps to 0 and sets ovf_o[k].
- Overflow, SAT_MODE=1: an increment attempted at all-ones leaves the counter at all-ones and sets ovf_o[k].
- The cycle counter follows the same wrap/saturate rule but has no overflow flag.
- ovf_o bits are sticky and cleared only by clr_i or rst_i.
- Snapshot: on an edge with snap_i=1, every shadow register gets the live value as it was before that edge's update.
  - This applies even when clr_i or counting occur on the same edge.
  - Shadow registers are unaffected by clr_i.
- Read: rd_data_o at edge t+1 = shadow[rd_sel_i] as held before edge t+1. A snapshot on the same edge is visible one cycle later.
  - rd_sel_i > NUM_CH reads 0.

## Timing
- Event-to-count latency: 1 edge. A strobe sampled at edge t is reflected in the counter after edge t.
- Snapshot-to-read latency: snap_i at edge t, then rd_data_o valid after edge t+1 with rd_sel_i held.
- clr_i takes effect in 1 edge. The edge after the clear is the first counted cycle if en_i=1.
- done_o and cycle_o are registered outputs with no combinational path from the inputs.
- Reset asserted mid-run zeroes everything on the next edge, including a pending snapshot. rst_i wins over snap_i on the same edge.

## Test plan
- Reset/idle:
  - Stimulus: rst_i=1 for 2 cycles, then en_i=0 with event_i=4'hF for 10 cycles.
  - Required: all outputs 0, counters stay 0.
- Basic count and limit:
  - Stimulus: limit_i=64, en_i=1, event_i[0] high every cycle, event_i[1] high every 3rd cycle starting at cycle 0.
  - Required: done_o rises on the edge where cycle_o=64; ch0=64, ch1=22. Counts are frozen 10 cycles later.
- Wrap vs saturate:
  - Stimulus: CNT_W=8, 300 cycles of event_i[2]=1.
  - Required, SAT_MODE=0: ch2=44 and ovf_o[2]=1.
  - Required, SAT_MODE=1: ch2=255 and ovf_o[2]=1. ovf_o[3]=0 throughout.
- Snapshot coherence:
  - Stimulus: after 20 counted cycles with event_i[0]=1, assert snap_i and clr_i on the same edge, then read sel 0 and sel NUM_CH.
  - Required: rd_data_o=20 for both selects, live counters=0, ovf_o=0, done_o=0.
- Read boundaries:
  - Stimulus: rd_sel_i=NUM_CH+1, and a snap on the same edge as a read of sel 0.
  - Required: the first returns 0; the second returns the old shadow, and the new value appears one cycle later.
- Reset mid-run:
  - Stimulus: with limit_i=64, assert rst_i at cycle 30 together with snap_i=1, then release.
  - Required: all counters, shadows and flags are 0; counting restarts from 0 and done_o rises after 64 further active cycles.
